// File: rtl/vector_burst_mem.sv
// Burst-oriented word memory: one request moves up to BURST_MAX words,
// writes throttled by DinValid, reads streamed after a fixed latency.
module vector_burst_mem #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int DEPTH     = 4096,
    parameter int RD_LAT    = 2,
    parameter int BURST_MAX = 16
) (
    input  logic                         Clk1,
    input  logic                         Reset,
    input  logic                         Req,
    input  logic                         WR,
    input  logic [ADDR_W-1:0]            Addr,
    input  logic [$clog2(BURST_MAX):0]   Len,
    input  logic [DATA_W-1:0]            DataIn,
    input  logic                         DinValid,
    output logic                         Ready,
    output logic [DATA_W-1:0]            DataOut,
    output logic                         RdValid,
    output logic                         Done,
    output logic                         Err
);

    localparam int LW = $clog2(BURST_MAX) + 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WW = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [LW-1:0]     BMAX  = LW'(BURST_MAX);
    localparam logic [WW-1:0]     WLAST = WW'(RD_LAT - 2);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RDWAIT,
        READ,
        DONE
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   faddr;
    logic [LW-1:0]       len_q;
    logic [LW-1:0]       len_eff;
    logic [LW-1:0]       cnt;
    logic [WW-1:0]       wcnt;
    logic                accept;
    logic                bad;
    logic                we;
    logic                fetch;

    function automatic logic [ADDR_W-1:0] nxt(input logic [ADDR_W-1:0] a);
        return (a == LAST) ? '0 : a + 1'b1;
    endfunction

    assign Ready  = (state == IDLE) && Reset;
    assign accept = Req && Ready;
    assign bad    = 32'(Addr) >= 32'(DEPTH);
    assign we     = (state == WRITE) && DinValid;

    always_comb begin
        len_eff = Len;
        if (Len == '0)
            len_eff = LW'(1);
        else if (Len > BMAX)
            len_eff = BMAX;
    end

    // Read beats are issued here; with RD_LAT=1 the first beat issues on accept.
    always_comb begin
        fetch = 1'b0;
        faddr = addr_q;
        unique case (state)
            IDLE: begin
                fetch = accept && !bad && !WR && (RD_LAT == 1);
                faddr = Addr;
            end
            RDWAIT:  fetch = (wcnt == WLAST);
            READ:    fetch = (cnt != len_q);
            default: fetch = 1'b0;
        endcase
    end

    always_ff @(posedge Clk1) begin
        if (we)
            mem[addr_q[AW-1:0]] <= DataIn;
    end

    always_ff @(posedge Clk1 or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            RdValid <= 1'b0;
            Done    <= 1'b0;
            Err     <= 1'b0;
            DataOut <= '0;
            cnt     <= '0;
            wcnt    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
        end else begin
            Done    <= 1'b0;
            Err     <= 1'b0;
            RdValid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q <= Addr;
                        len_q  <= len_eff;
                        if (bad)
                            Err <= 1'b1;
                        else if (WR)
                            state <= WRITE;
                        else if (RD_LAT > 1)
                            state <= RDWAIT;
                        else
                            state <= READ;
                    end
                end
                WRITE: begin
                    if (DinValid) begin
                        addr_q <= nxt(addr_q);
                        cnt    <= cnt + 1'b1;
                        if (cnt == len_q - 1'b1) begin
                            state <= DONE;
                            Done  <= 1'b1;
                        end
                    end
                end
                RDWAIT: begin
                    if (wcnt == WLAST)
                        state <= READ;
                    else
                        wcnt <= wcnt + 1'b1;
                end
                READ: begin
                    if (cnt == len_q) begin
                        state <= DONE;
                        Done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    cnt   <= '0;
                    wcnt  <= '0;
                end
                default: state <= IDLE;
            endcase
            if (fetch) begin
                DataOut <= mem[faddr[AW-1:0]];
                RdValid <= 1'b1;
                addr_q  <= nxt(faddr);
                cnt     <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vector_burst_mem.sv
// Bench for vector_burst_mem: directed and random bursts against a
// cycle-timeline model derived from the request/latency rules.
module tb_vector_burst_mem;

    localparam int DEPTH  = 4096;
    localparam int RD_LAT = 2;
    localparam int BMAX   = 16;
    localparam int LW     = $clog2(BMAX) + 1;

    logic          Clk1 = 1'b0;
    logic          Reset = 1'b0;
    logic          Req = 1'b0;
    logic          WR = 1'b0;
    logic [15:0]   Addr = '0;
    logic [LW-1:0] Len = '0;
    logic [15:0]   DataIn = '0;
    logic          DinValid = 1'b0;
    logic          Ready;
    logic [15:0]   DataOut;
    logic          RdValid;
    logic          Done;
    logic          Err;

    vector_burst_mem #(
        .DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH),
        .RD_LAT(RD_LAT), .BURST_MAX(BMAX)
    ) dut (
        .Clk1(Clk1), .Reset(Reset), .Req(Req), .WR(WR),
        .Addr(Addr), .Len(Len), .DataIn(DataIn), .DinValid(DinValid),
        .Ready(Ready), .DataOut(DataOut), .RdValid(RdValid),
        .Done(Done), .Err(Err)
    );

    always #5 Clk1 = ~Clk1;

    int cyc = 0;
    always @(posedge Clk1) cyc <= cyc + 1;

    // Reference memory and per-edge expectations (key = capturing edge).
    logic [15:0] mdl [DEPTH];
    bit          kn  [DEPTH];
    bit          exp_rv [int];
    logic [15:0] exp_do [int];
    bit          exp_dk [int];
    bit          exp_done [int];
    bit          exp_err [int];
    bit          exp_busy [int];
    bit          obs_rv [int];
    logic [15:0] obs_do [int];
    bit          obs_done [int];
    bit          obs_err [int];
    bit          obs_rdy [int];

    int n_chk  = 0;
    int n_fail = 0;

    logic [15:0] wd [$];
    bit          wv [$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, expv, cyc);
        end
    endtask

    logic [15:0] hold = '0;
    bit          hold_k = 1'b1;

    always @(negedge Clk1) begin : mon
        int l;
        l = cyc + 1;
        obs_rv[l]   = RdValid;
        obs_do[l]   = DataOut;
        obs_done[l] = Done;
        obs_err[l]  = Err;
        obs_rdy[l]  = Ready;
        if (!Reset) begin
            chk("rst_ready", 32'(Ready), 0);
            chk("rst_rdvalid", 32'(RdValid), 0);
            chk("rst_done", 32'(Done), 0);
            chk("rst_err", 32'(Err), 0);
            chk("rst_dataout", 32'(DataOut), 0);
            hold   = '0;
            hold_k = 1'b1;
        end else begin
            chk("ready", 32'(Ready), 32'(!exp_busy.exists(l)));
            chk("rdvalid", 32'(RdValid), 32'(exp_rv.exists(l)));
            chk("done", 32'(Done), 32'(exp_done.exists(l)));
            chk("err", 32'(Err), 32'(exp_err.exists(l)));
            if (exp_rv.exists(l)) begin
                if (exp_dk[l]) begin
                    chk("rdata", 32'(DataOut), 32'(exp_do[l]));
                    hold   = exp_do[l];
                    hold_k = 1'b1;
                end else begin
                    hold_k = 1'b0;
                end
            end else if (hold_k) begin
                chk("dout_hold", 32'(DataOut), 32'(hold));
            end
        end
    end

    task automatic tick();
        @(posedge Clk1);
        #2;
    endtask

    task automatic noise();
        Req  = 1'($urandom);
        WR   = 1'($urandom);
        Addr = 16'($urandom);
        Len  = LW'($urandom);
    endtask

    // Issues one request; returns the accept edge once the block is idle again.
    task automatic issue(input bit wr, input int a, input int ln, output int k);
        int          len;
        int          e;
        int          w;
        int          idx;
        int          done;
        bit          v;
        logic [15:0] d;
        bit          pat [$];
        logic [15:0] dat [$];
        k    = cyc + 1;
        len  = (ln == 0) ? 1 : ((ln > BMAX) ? BMAX : ln);
        Req  = 1'b1;
        WR   = wr;
        Addr = 16'(a);
        Len  = LW'(ln);
        DinValid = 1'b0;
        if (a >= DEPTH) begin
            exp_err[k+1] = 1'b1;
            tick();
            Req = 1'b0;
            wd.delete();
            wv.delete();
            return;
        end
        if (wr) begin
            e = k;
            w = 0;
            idx = 0;
            while (w < len) begin
                e++;
                v = (idx < wv.size()) ? wv[idx] : ($urandom_range(0, 9) < 7);
                d = (v && w < wd.size()) ? wd[w] : 16'($urandom);
                pat.push_back(v);
                dat.push_back(d);
                if (v) begin
                    mdl[(a + w) % DEPTH] = d;
                    kn[(a + w) % DEPTH]  = 1'b1;
                    w++;
                end
                idx++;
            end
            done = e + 1;
        end else begin
            for (int i = 0; i < len; i++) begin
                exp_rv[k+RD_LAT+i] = 1'b1;
                exp_do[k+RD_LAT+i] = mdl[(a + i) % DEPTH];
                exp_dk[k+RD_LAT+i] = kn[(a + i) % DEPTH];
            end
            done = k + RD_LAT + len;
        end
        exp_done[done] = 1'b1;
        for (int j = k + 1; j <= done; j++) exp_busy[j] = 1'b1;
        tick();
        for (int i = 0; i < pat.size(); i++) begin
            noise();
            DinValid = pat[i];
            DataIn   = dat[i];
            tick();
        end
        DinValid = 1'b0;
        while (cyc < done) begin
            noise();
            tick();
        end
        Req = 1'b0;
        wd.delete();
        wv.delete();
    endtask

    function automatic int count_rv(input int from, input int to);
        int n;
        n = 0;
        for (int j = from; j <= to; j++)
            if (obs_rv.exists(j) && obs_rv[j]) n++;
        return n;
    endfunction

    initial begin : main
        int k;
        int a;
        bit wr;
        repeat (3) tick();
        Reset = 1'b1;
        #1 chk("ready_after_release", 32'(Ready), 1);

        for (int i = 0; i < 4; i++) begin wd.push_back(16'hA000 + 16'(i)); wv.push_back(1); end
        issue(1, 'h10, 4, k);
        chk("w38_done", 32'(obs_done[k+5]), 1);
        chk("w38_done_early", 32'(obs_done[k+4]), 0);
        issue(0, 'h10, 4, k);
        chk("r38_not_before_lat", 32'(obs_rv[k+1]), 0);
        for (int i = 0; i < 4; i++) begin
            chk("r38_valid", 32'(obs_rv[k+2+i]), 1);
            chk("r38_data", 32'(obs_do[k+2+i]), 32'(16'hA000 + 16'(i)));
        end
        chk("r38_done", 32'(obs_done[k+6]), 1);

        for (int i = 0; i < 4; i++) wd.push_back(16'hD000 + 16'(i));
        issue(1, 'h40, 4, k);
        wd = '{16'hC000, 16'hC001, 16'hC002};
        wv = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        issue(1, 'h40, 3, k);
        chk("w39_done", 32'(obs_done[k+6]), 1);
        chk("w39_done_early", 32'(obs_done[k+5]), 0);
        issue(0, 'h40, 4, k);
        chk("r39_w0", 32'(obs_do[k+2]), 32'h0000C000);
        chk("r39_w2", 32'(obs_do[k+4]), 32'h0000C002);
        chk("r39_untouched", 32'(obs_do[k+5]), 32'h0000D003);

        for (int i = 0; i < 4; i++) begin wd.push_back(16'hB000 + 16'(i)); wv.push_back(1); end
        issue(1, 'hFFE, 4, k);
        issue(0, 'hFFE, 4, k);
        for (int i = 0; i < 4; i++)
            chk("r40_wrap", 32'(obs_do[k+2+i]), 32'(16'hB000 + 16'(i)));
        issue(0, 0, 2, k);
        chk("r40_at0", 32'(obs_do[k+2]), 32'h0000B002);
        chk("r40_at1", 32'(obs_do[k+3]), 32'h0000B003);

        issue(0, 'h1000, 4, k);
        tick();
        tick();
        chk("e41_err", 32'(obs_err[k+1]), 1);
        chk("e41_err_once", 32'(obs_err[k+2]), 0);
        chk("e41_ready", 32'(obs_rdy[k+1]), 1);
        chk("e41_no_rd", 32'(count_rv(k + 1, k + 2)), 0);

        issue(0, 'h10, 0, k);
        chk("l42_len0", 32'(count_rv(k + 1, k + RD_LAT + 1)), 1);
        issue(0, 'h10, BMAX + 5, k);
        chk("l42_clamp", 32'(count_rv(k + 1, k + RD_LAT + BMAX)), BMAX);

        repeat (60) begin
            wr = 1'($urandom);
            if ($urandom_range(0, 9) == 0)
                a = DEPTH + $urandom_range(0, 100);
            else
                a = ('hFF0 + $urandom_range(0, 47)) % DEPTH;
            issue(wr, a, $urandom_range(0, BMAX + 5), k);
            repeat ($urandom_range(0, 2)) tick();
        end

        for (int i = 0; i < 8; i++) begin wd.push_back(16'h5A00 + 16'(i)); wv.push_back(1); end
        issue(1, 'h200, 8, k);
        k = cyc + 1;
        Req = 1'b1; WR = 1'b0; Addr = 16'h0200; Len = LW'(8);
        for (int i = 0; i < 8; i++) begin
            exp_rv[k+RD_LAT+i] = 1'b1;
            exp_do[k+RD_LAT+i] = mdl['h200 + i];
            exp_dk[k+RD_LAT+i] = 1'b1;
        end
        exp_done[k+RD_LAT+8] = 1'b1;
        for (int j = k + 1; j <= k + RD_LAT + 8; j++) exp_busy[j] = 1'b1;
        tick();
        Req = 1'b0;
        tick();
        tick();
        #1;
        chk("r43_beat2_valid", 32'(RdValid), 1);
        chk("r43_beat2_data", 32'(DataOut), 32'h00005A01);
        Reset = 1'b0;
        #1;
        chk("r43_rdvalid_async", 32'(RdValid), 0);
        chk("r43_done_async", 32'(Done), 0);
        chk("r43_ready_async", 32'(Ready), 0);
        chk("r43_dout_async", 32'(DataOut), 0);
        exp_rv.delete(); exp_do.delete(); exp_dk.delete();
        exp_done.delete(); exp_busy.delete(); exp_err.delete();
        tick();
        tick();
        Reset = 1'b1;
        issue(0, 'h200, 8, k);
        chk("r43_relaunch", 32'(obs_rv[k+2]), 1);
        chk("r43_kept", 32'(obs_do[k+9]), 32'h00005A07);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vector_burst_mem.md
VECTOR_BURST_MEM -- requirements
Module: vector_burst_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 16, word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 16, address width in bits.
REQ-003 SHALL have parameter DEPTH, default 4096, number of words stored; DEPTH <= 2**ADDR_W.
REQ-004 SHALL have parameter RD_LAT, default 2, accept-to-first-read-data latency in cycles; RD_LAT >= 1.
REQ-005 SHALL have parameter BURST_MAX, default 16, maximum words per request (vector length).
REQ-006 SHALL have port Clk1, input, 1, the single clock; all state updates on its rising edge.
REQ-007 SHALL have port Reset, input, 1, reset: asynchronous, active-low.
REQ-008 SHALL have port Req, input, 1, request strobe.
REQ-009 SHALL have port WR, input, 1, request direction: 1 = write, 0 = read; sampled with Req.
REQ-010 SHALL have port Addr, input, ADDR_W, start word address; sampled with Req.
REQ-011 SHALL have port Len, input, $clog2(BURST_MAX)+1, burst length in words; sampled with Req.
REQ-012 SHALL have port DataIn, input, DATA_W, write data.
REQ-013 SHALL have port DinValid, input, 1, DataIn holds a valid write beat.
REQ-014 SHALL have port Ready, output, 1, block is able to accept a request.
REQ-015 SHALL have port DataOut, output, DATA_W, read data.
REQ-016 SHALL have port RdValid, output, 1, DataOut holds a valid read beat.
REQ-017 SHALL have port Done, output, 1, single-cycle pulse marking request completion.
REQ-018 SHALL have port Err, output, 1, single-cycle pulse marking a rejected request.

Function
REQ-019 SHALL implement states IDLE, WRITE, RDWAIT, READ and DONE.
REQ-020 SHALL drive Ready = 1 only in IDLE with Reset high; a request is accepted on the rising edge where Req && Ready.
REQ-021 SHALL, on accept, latch WR, Addr and Len; an effective length of 0 SHALL be treated as 1, and any value above BURST_MAX SHALL be clamped to BURST_MAX.
REQ-022 SHALL, on accept with Addr >= DEPTH, perform no memory access, pulse Err for 1 cycle and remain in IDLE.
REQ-023 SHALL compute beat i's address as (Addr + i) mod DEPTH, so bursts wrap from DEPTH-1 to 0.
REQ-024 Write path, IDLE->WRITE on accept: each cycle in WRITE with DinValid = 1 SHALL write DataIn to the current address and advance the beat.
REQ-025 Write path stall: a WRITE cycle with DinValid = 0 SHALL neither write nor advance.
REQ-026 Write path exit: after the last beat is written the state SHALL go WRITE->DONE.
REQ-027 Read path, IDLE->RDWAIT on accept: the block SHALL hold RDWAIT for RD_LAT-1 cycles, skipping RDWAIT when RD_LAT = 1.
REQ-028 Read path, READ: the block SHALL present one word per cycle with RdValid = 1 for exactly Len consecutive cycles; reads have no backpressure.
REQ-029 Read path latency: the first RdValid SHALL occur RD_LAT cycles after the accept edge.
REQ-030 Read path exit: after the last beat the state SHALL go READ->DONE.
REQ-031 DONE SHALL last 1 cycle with Done = 1, then return to IDLE; Ready returns to 1 in the cycle after Done.
REQ-032 Req SHALL be ignored while Ready = 0, and SHALL not be queued.
REQ-033 A read of a location inside the same burst that wrote it SHALL return the newly written value; memory contents SHALL NOT be initialised by reset.
REQ-034 DataOut SHALL hold its last value when RdValid = 0.

Reset
REQ-035 While Reset = 0 the block SHALL force state IDLE, and Ready, RdValid, Done and Err to 0, DataOut to 0 and the beat counter to 0.
REQ-036 Reset asserted mid-burst SHALL abort the request immediately; already-written words SHALL remain in memory and no Done SHALL be generated.
REQ-037 The first request SHALL be acceptable on the first rising edge after Reset returns to 1.

Verification
REQ-038 Write Addr=0x0010, Len=4, data 0xA000..0xA003 with DinValid held 1 -> Done pulses 1 cycle after the 4th beat; a subsequent read of Len=4 returns 0xA000..0xA003 with first RdValid at accept+2.
REQ-039 Write Len=3 with DinValid = 1,0,0,1,1 -> exactly 3 writes occur and Done follows the 5th write-phase cycle.
REQ-040 With DEPTH=4096, write Addr=0x0FFE, Len=4 -> words land at 0x0FFE, 0x0FFF, 0x0000, 0x0001; readback confirms.
REQ-041 Read Addr=0x1000 (>= DEPTH) -> Err = 1 for 1 cycle, no RdValid, no Done, Ready stays 1.
REQ-042 Len=0 read -> 1 beat; Len=BURST_MAX+5 -> BURST_MAX beats.
REQ-043 Reset driven low during beat 2 of a Len=8 read -> RdValid drops asynchronously, no Done; after release a new request is accepted on the next edge.
